pid_servo_rt: RTL

Runtime-programmable, parametrised PID servo for the 100 MHz digital lock loop. It takes one signed error sample per clock and produces a clamped actuator word four cycles later.
- Gains and output limits are loaded at run time through a strobe/acknowledge interface, replacing coefficients fixed at elaboration.
- Adds an explicit integrator with conditional-integration anti-windup, programmable output rails and railed flags.
- Sits between the ADC error path and the DAC/actuator output.

---
 rtl/pid_servo_pkg.sv | 24 ++
 rtl/pid_sat_round.sv | 42 ++++
 rtl/pid_servo_rt.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pid_servo_pkg.sv
// Shared widths, default coefficient/limit constants and rail-flag indices
// for the runtime-programmable PID servo.
package pid_servo_pkg;

  localparam int unsigned W_IN_DEF   = 16;
  localparam int unsigned W_OUT_DEF  = 16;
  localparam int unsigned W_COEF_DEF = 36;
  localparam int unsigned W_ACC_DEF  = 48;
  localparam int unsigned FRAC       = 26;

  localparam longint ONE    = 64'sd1 <<< FRAC;
  localparam longint KP_DEF = ONE;
  localparam longint KI_DEF = 64'sd0;
  localparam longint KD_DEF = 64'sd0;

  localparam int unsigned RAIL_HI = 1;
  localparam int unsigned RAIL_LO = 0;

  typedef enum logic {
    LD_IDLE,
    LD_PEND
  } ld_state_e;

endpackage

// File: rtl/pid_sat_round.sv
// Round half-up, drop FRAC fraction bits and clamp the wide PID sum to the
// programmable output rails, flagging which rail was reached.
module pid_sat_round
  import pid_servo_pkg::*;
#(
  parameter int unsigned W_SUM = 55,
  parameter int unsigned W_OUT = W_OUT_DEF,
  parameter int unsigned FRAC  = pid_servo_pkg::FRAC
) (
  input  logic signed [W_SUM-1:0] s_i,
  input  logic signed [W_OUT-1:0] lim_hi_i,
  input  logic signed [W_OUT-1:0] lim_lo_i,
  output logic signed [W_OUT-1:0] y_o,
  output logic        [1:0]       rail_o
);

  localparam logic signed [W_SUM:0] HALF =
    {{(W_SUM-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [W_SUM:0] biased;
  logic signed [W_SUM:0] shifted;
  logic signed [W_SUM:0] hi_x;
  logic signed [W_SUM:0] lo_x;

  always_comb begin
    biased  = $signed({s_i[W_SUM-1], s_i}) + HALF;
    shifted = biased >>> FRAC;
    hi_x    = {{(W_SUM+1-W_OUT){lim_hi_i[W_OUT-1]}}, lim_hi_i};
    lo_x    = {{(W_SUM+1-W_OUT){lim_lo_i[W_OUT-1]}}, lim_lo_i};
    rail_o  = '0;
    y_o     = shifted[W_OUT-1:0];
    // Landing exactly on a rail counts as railed so the integrator stops there.
    if (shifted >= hi_x) begin
      y_o             = lim_hi_i;
      rail_o[RAIL_HI] = 1'b1;
    end else if (shifted <= lo_x) begin
      y_o             = lim_lo_i;
      rail_o[RAIL_LO] = 1'b1;
    end
  end

endmodule

// File: rtl/pid_servo_rt.sv
// Four-stage PID servo with runtime-loadable gains/rails, saturating
// integrator with conditional-integration anti-windup and railed flags.
module pid_servo_rt
  import pid_servo_pkg::*;
#(
  parameter int unsigned W_IN   = W_IN_DEF,
  parameter int unsigned W_OUT  = W_OUT_DEF,
  parameter int unsigned W_COEF = W_COEF_DEF,
  parameter int unsigned FRAC   = pid_servo_pkg::FRAC,
  parameter int unsigned W_ACC  = W_ACC_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     on_in,
  input  logic                     hold_in,
  input  logic signed [W_IN-1:0]   e_in,
  input  logic signed [W_COEF-1:0] kp_in,
  input  logic signed [W_COEF-1:0] ki_in,
  input  logic signed [W_COEF-1:0] kd_in,
  input  logic signed [W_OUT-1:0]  lim_hi_in,
  input  logic signed [W_OUT-1:0]  lim_lo_in,
  input  logic                     coef_load_in,
  output logic                     coef_ack_out,
  output logic                     coef_err_out,
  output logic signed [W_OUT-1:0]  u_out,
  output logic        [1:0]        railed_out,
  output logic                     valid_out
);

  localparam int unsigned W_D   = W_IN + 1;
  localparam int unsigned W_P   = W_COEF + W_IN;
  localparam int unsigned W_DD  = W_COEF + W_D;
  localparam int unsigned W_SUM = ((W_DD > W_ACC) ? W_DD : W_ACC) + 2;
  localparam int unsigned W_AS  = ((W_P > W_ACC) ? W_P : W_ACC) + 1;

  localparam logic signed [W_COEF-1:0] KP_RST = W_COEF'(64'sd1 <<< FRAC);
  localparam logic signed [W_COEF-1:0] KI_RST = W_COEF'(KI_DEF);
  localparam logic signed [W_COEF-1:0] KD_RST = W_COEF'(KD_DEF);
  localparam logic signed [W_OUT-1:0]  HI_RST = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0]  LO_RST = {1'b1, {(W_OUT-1){1'b0}}};
  localparam logic signed [W_ACC-1:0]  ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic signed [W_ACC-1:0]  ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};
  localparam logic signed [W_AS-1:0]   ACC_MAX_X = W_AS'(ACC_MAX);
  localparam logic signed [W_AS-1:0]   ACC_MIN_X = W_AS'(ACC_MIN);

  // Coefficient loader: shadow capture, then atomic apply one cycle later.
  ld_state_e               ld_q, ld_d;
  logic signed [W_COEF-1:0] sh_kp_q, sh_ki_q, sh_kd_q;
  logic signed [W_OUT-1:0]  sh_hi_q, sh_lo_q;
  logic signed [W_COEF-1:0] kp_q, ki_q, kd_q;
  logic signed [W_OUT-1:0]  lim_hi_q, lim_lo_q;
  logic                     apply;
  logic                     lim_ok;

  always_comb begin
    ld_d         = ld_q;
    apply        = 1'b0;
    coef_ack_out = 1'b0;
    coef_err_out = 1'b0;
    lim_ok       = (sh_lo_q <= sh_hi_q);
    case (ld_q)
      LD_IDLE: if (coef_load_in) ld_d = LD_PEND;
      LD_PEND: begin
        // A fresh strobe in the apply cycle keeps the set pending instead.
        if (!coef_load_in) begin
          ld_d         = LD_IDLE;
          apply        = lim_ok & ~rst_in;
          coef_ack_out = lim_ok & ~rst_in;
          coef_err_out = ~lim_ok & ~rst_in;
        end
      end
      default: ld_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ld_q     <= LD_IDLE;
      sh_kp_q  <= '0;
      sh_ki_q  <= '0;
      sh_kd_q  <= '0;
      sh_hi_q  <= '0;
      sh_lo_q  <= '0;
      kp_q     <= KP_RST;
      ki_q     <= KI_RST;
      kd_q     <= KD_RST;
      lim_hi_q <= HI_RST;
      lim_lo_q <= LO_RST;
    end else begin
      ld_q <= ld_d;
      if (coef_load_in) begin
        sh_kp_q <= kp_in;
        sh_ki_q <= ki_in;
        sh_kd_q <= kd_in;
        sh_hi_q <= lim_hi_in;
        sh_lo_q <= lim_lo_in;
      end
      if (apply) begin
        kp_q     <= sh_kp_q;
        ki_q     <= sh_ki_q;
        kd_q     <= sh_kd_q;
        lim_hi_q <= sh_hi_q;
        lim_lo_q <= sh_lo_q;
      end
    end
  end

  // Datapath. e_q doubles as e_prev for the next sample's difference.
  logic signed [W_IN-1:0]  e_q;
  logic signed [W_D-1:0]   d_q;
  logic signed [W_P-1:0]   p_q, i_q, p_d, i_d;
  logic signed [W_DD-1:0]  dd_q, dd_d;
  logic signed [W_P-1:0]   p3_q;
  logic signed [W_DD-1:0]  dd3_q;
  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic signed [W_AS-1:0]  acc_sum;
  logic signed [W_SUM-1:0] s_d;
  logic signed [W_OUT-1:0] u_q, u_d;
  logic        [1:0]       rail_q, rail_d;
  logic        [3:0]       v_q;
  logic                    skip;

  always_comb begin
    p_d     = W_P'(kp_q) * W_P'(e_q);
    i_d     = W_P'(ki_q) * W_P'(e_q);
    dd_d    = W_DD'(kd_q) * W_DD'(d_q);
    acc_sum = W_AS'(acc_q) + W_AS'(i_q);
    skip    = hold_in
            | (rail_q[RAIL_HI] & ~i_q[W_P-1] & (|i_q))
            | (rail_q[RAIL_LO] & i_q[W_P-1]);
    acc_d   = acc_q;
    if (!skip) begin
      if (acc_sum > ACC_MAX_X)      acc_d = ACC_MAX;
      else if (acc_sum < ACC_MIN_X) acc_d = ACC_MIN;
      else                          acc_d = acc_sum[W_ACC-1:0];
    end
    s_d = W_SUM'(p3_q) + W_SUM'(acc_q) + W_SUM'(dd3_q);
  end

  pid_sat_round #(
    .W_SUM (W_SUM),
    .W_OUT (W_OUT),
    .FRAC  (FRAC)
  ) u_sat (
    .s_i      (s_d),
    .lim_hi_i (lim_hi_q),
    .lim_lo_i (lim_lo_q),
    .y_o      (u_d),
    .rail_o   (rail_d)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || !on_in) begin
      e_q    <= '0;
      d_q    <= '0;
      p_q    <= '0;
      i_q    <= '0;
      dd_q   <= '0;
      p3_q   <= '0;
      dd3_q  <= '0;
      acc_q  <= '0;
      u_q    <= '0;
      rail_q <= '0;
      v_q    <= '0;
    end else begin
      e_q    <= e_in;
      d_q    <= W_D'(e_in) - W_D'(e_q);
      p_q    <= p_d;
      i_q    <= i_d;
      dd_q   <= dd_d;
      p3_q   <= p_q;
      dd3_q  <= dd_q;
      acc_q  <= acc_d;
      u_q    <= u_d;
      rail_q <= rail_d;
      v_q    <= {v_q[2:0], 1'b1};
    end
  end

  assign u_out      = u_q;
  assign railed_out = rail_q;
  assign valid_out  = v_q[3];

endmodule
